// File: rtl/transmit_sequencer_if.sv
// Host/pulser-side bundle for transmit_sequencer: configuration, control requests and
// the registered status/pulse outputs.
//
// Handshake semantics:
//   load_delays, start_transmit, abort and next_aline are level requests.
//   They are sampled on every rising edge, but only in the states that accept them.
//   ready is high exactly while a start_transmit would be accepted.
//   transmit_complete is held until next_aline is seen.
//   Configuration buses are sampled only in the LOAD cycle.
interface transmit_sequencer_if #(
  parameter int NUM_CH    = 8,
  parameter int PULSE_LEN = 32,
  parameter int DELAY_W   = 16,
  parameter int BURST_W   = 4
);
  logic [NUM_CH-1:0]         used_channels;
  logic [PULSE_LEN-1:0]      pulse_shape;
  logic [NUM_CH*DELAY_W-1:0] delays;
  logic [BURST_W-1:0]        burst_count;
  logic                      load_delays;
  logic                      start_transmit;
  logic                      abort;
  logic                      next_aline;
  logic                      ready;
  logic                      transmit_in_progress;
  logic                      transmit_complete;
  logic                      aborted;
  logic                      switch;
  logic [NUM_CH-1:0]         ultrasound_pulses;
  logic [NUM_CH-1:0]         pulse_sent;

  modport master (
    output used_channels, pulse_shape, delays, burst_count,
           load_delays, start_transmit, abort, next_aline,
    input  ready, transmit_in_progress, transmit_complete, aborted,
           switch, ultrasound_pulses, pulse_sent
  );

  modport slave (
    input  used_channels, pulse_shape, delays, burst_count,
           load_delays, start_transmit, abort, next_aline,
    output ready, transmit_in_progress, transmit_complete, aborted,
           switch, ultrasound_pulses, pulse_sent
  );
endinterface

// File: rtl/transmit_sequencer.sv
// Multi-channel ultrasound transmit sequencer.
// Latches per-channel delays and fires delayed, shaped pulses in bursts separated by guard gaps.
module transmit_sequencer #(
  parameter int NUM_CH       = 8,
  parameter int PULSE_LEN    = 32,
  parameter int DELAY_W      = 16,
  parameter int BURST_W      = 4,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  transmit_sequencer_if.slave bus,
  output logic [2:0]          dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_ARMED    = 3'd2,
    S_OPEN     = 3'd3,
    S_TRANSMIT = 3'd4,
    S_GUARD    = 3'd5,
    S_CLOSE    = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  // Two spare bits let the shot index pass max delay + PULSE_LEN before saturating.
  localparam int T_W   = DELAY_W + 2;
  localparam int IDX_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam int GC_W  = $clog2(GUARD_CYCLES + 1);
  localparam logic [T_W-1:0]     PL         = T_W'(PULSE_LEN);
  localparam logic [GC_W-1:0]    GUARD_LAST = GC_W'(GUARD_CYCLES - 1);
  localparam logic [BURST_W-1:0] ONE_SHOT   = BURST_W'(1);

  state_t                    state_q;
  logic [NUM_CH-1:0]         mask_q;
  logic [PULSE_LEN-1:0]      shape_q;
  logic [NUM_CH*DELAY_W-1:0] delays_q;
  logic [BURST_W-1:0]        shots_q;
  logic [T_W-1:0]            t_q;
  logic [GC_W-1:0]           guard_q;

  logic              ready_q, tip_q, complete_q, aborted_q, switch_q;
  logic [NUM_CH-1:0] pulses_q, sent_q;

  logic [T_W-1:0]    t_d;
  logic [NUM_CH-1:0] pulses_d, sent_d;

  // Outputs are registered, so the next TRANSMIT index is computed one cycle ahead.
  assign t_d = (state_q == S_TRANSMIT) ? ((&t_q) ? t_q : t_q + T_W'(1)) : '0;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [T_W-1:0] dly;
    logic [T_W-1:0] diff;
    assign dly         = T_W'(delays_q[i*DELAY_W +: DELAY_W]);
    assign diff        = t_d - dly;
    assign pulses_d[i] = mask_q[i] && (t_d >= dly) && (diff < PL) && shape_q[diff[IDX_W-1:0]];
    assign sent_d[i]   = !mask_q[i] || (t_d >= dly + PL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      shape_q    <= '0;
      delays_q   <= '0;
      shots_q    <= '0;
      t_q        <= '0;
      guard_q    <= '0;
      ready_q    <= 1'b0;
      tip_q      <= 1'b0;
      complete_q <= 1'b0;
      aborted_q  <= 1'b0;
      switch_q   <= 1'b0;
      pulses_q   <= '0;
      sent_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.load_delays) state_q <= S_LOAD;
        end
        S_LOAD: begin
          mask_q   <= bus.used_channels;
          shape_q  <= bus.pulse_shape;
          delays_q <= bus.delays;
          shots_q  <= (bus.burst_count == '0) ? ONE_SHOT : bus.burst_count;
          ready_q  <= 1'b1;
          state_q  <= S_ARMED;
        end
        S_ARMED: begin
          if (bus.abort) begin
            ready_q    <= 1'b0;
            complete_q <= 1'b1;
            aborted_q  <= 1'b1;
            state_q    <= S_DONE;
          end else if (bus.load_delays) begin
            ready_q <= 1'b0;
            state_q <= S_LOAD;
          end else if (bus.start_transmit) begin
            ready_q  <= 1'b0;
            switch_q <= 1'b1;
            tip_q    <= 1'b1;
            pulses_q <= '0;
            sent_q   <= '0;
            t_q      <= '0;
            state_q  <= S_OPEN;
          end
        end
        S_OPEN, S_TRANSMIT, S_GUARD: begin
          if (bus.abort) begin
            // pulse_sent is left as-is so the host can see how far the shot got.
            switch_q   <= 1'b0;
            tip_q      <= 1'b0;
            pulses_q   <= '0;
            complete_q <= 1'b1;
            aborted_q  <= 1'b1;
            state_q    <= S_DONE;
          end else if (state_q == S_TRANSMIT && (&sent_q)) begin
            pulses_q <= '0;
            if (shots_q > ONE_SHOT) begin
              shots_q <= shots_q - ONE_SHOT;
              sent_q  <= '0;
              guard_q <= '0;
              state_q <= S_GUARD;
            end else begin
              switch_q <= 1'b0;
              tip_q    <= 1'b0;
              state_q  <= S_CLOSE;
            end
          end else if (state_q == S_GUARD && guard_q != GUARD_LAST) begin
            guard_q <= guard_q + GC_W'(1);
          end else begin
            t_q      <= t_d;
            pulses_q <= pulses_d;
            sent_q   <= sent_d;
            state_q  <= S_TRANSMIT;
          end
        end
        S_CLOSE: begin
          complete_q <= 1'b1;
          state_q    <= S_DONE;
        end
        S_DONE: begin
          if (bus.next_aline) begin
            complete_q <= 1'b0;
            aborted_q  <= 1'b0;
            sent_q     <= '0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ready                = ready_q;
  assign bus.transmit_in_progress = tip_q;
  assign bus.transmit_complete    = complete_q;
  assign bus.aborted              = aborted_q;
  assign bus.switch               = switch_q;
  assign bus.ultrasound_pulses    = pulses_q;
  assign bus.pulse_sent           = sent_q;
  assign dbg_state_o              = state_q;

endmodule

// File: tb/tb_transmit_sequencer.sv
// Directed bench for transmit_sequencer.
// A per-channel delay/shape model supplies the expected pulse and pulse_sent vectors.
module tb_transmit_sequencer;
  localparam int NUM_CH = 8, PULSE_LEN = 32, DELAY_W = 16, BURST_W = 4, GUARD_CYCLES = 4;
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_ARMED = 3'd2, S_OPEN = 3'd3,
                         S_TRANSMIT = 3'd4, S_GUARD = 3'd5, S_CLOSE = 3'd6, S_DONE = 3'd7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;

  transmit_sequencer_if #(.NUM_CH(NUM_CH), .PULSE_LEN(PULSE_LEN), .DELAY_W(DELAY_W),
                          .BURST_W(BURST_W)) bus ();

  transmit_sequencer #(.NUM_CH(NUM_CH), .PULSE_LEN(PULSE_LEN), .DELAY_W(DELAY_W),
                       .BURST_W(BURST_W), .GUARD_CYCLES(GUARD_CYCLES)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [NUM_CH-1:0]    m_mask;
  logic [PULSE_LEN-1:0] m_shape;
  int                   m_delay [NUM_CH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NUM_CH-1:0] exp_pulses(input int t);
    logic [NUM_CH-1:0] r = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (m_mask[i] && t >= m_delay[i] && t - m_delay[i] < PULSE_LEN) r[i] = m_shape[t - m_delay[i]];
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_sent(input int t);
    logic [NUM_CH-1:0] r = '0;
    for (int i = 0; i < NUM_CH; i++) r[i] = !m_mask[i] || (t >= m_delay[i] + PULSE_LEN);
    return r;
  endfunction

  task automatic load_cfg(input logic [NUM_CH-1:0] mask, input logic [PULSE_LEN-1:0] shape,
                          input int d [NUM_CH], input logic [BURST_W-1:0] burst);
    m_mask  = mask;
    m_shape = shape;
    for (int i = 0; i < NUM_CH; i++) begin
      m_delay[i] = d[i];
      bus.delays[i*DELAY_W +: DELAY_W] = DELAY_W'(d[i]);
    end
    bus.used_channels = mask;
    bus.pulse_shape   = shape;
    bus.burst_count   = burst;
    bus.load_delays   = 1'b1;
    tick();
    chk("load_state", dbg_state, S_LOAD);
    bus.load_delays = 1'b0;
    tick();
    chk("armed_state", dbg_state, S_ARMED);
    chk("armed_ready", bus.ready, 1'b1);
  endtask

  // Fires and then scrambles the config inputs, which must not disturb the shot.
  task automatic fire();
    bus.start_transmit = 1'b1;
    tick();
    chk("open_state", dbg_state, S_OPEN);
    chk("open_switch", bus.switch, 1'b1);
    chk("open_tip", bus.transmit_in_progress, 1'b1);
    chk("open_sent", bus.pulse_sent, '0);
    chk("open_ready", bus.ready, 1'b0);
    bus.start_transmit = 1'b0;
    bus.used_channels  = NUM_CH'($urandom);
    bus.pulse_shape    = PULSE_LEN'($urandom);
    bus.delays         = {$urandom, $urandom, $urandom, $urandom};
    tick();
  endtask

  task automatic run_shot(input int first_t, input int last_t);
    for (int t = first_t; t <= last_t; t++) begin
      chk($sformatf("tx_state_t%0d", t), dbg_state, S_TRANSMIT);
      chk($sformatf("tx_switch_t%0d", t), bus.switch, 1'b1);
      chk($sformatf("tx_pulses_t%0d", t), bus.ultrasound_pulses, exp_pulses(t));
      chk($sformatf("tx_sent_t%0d", t), bus.pulse_sent, exp_sent(t));
      tick();
    end
  endtask

  task automatic finish_txn();
    chk("close_state", dbg_state, S_CLOSE);
    chk("close_switch", bus.switch, 1'b0);
    chk("close_pulses", bus.ultrasound_pulses, '0);
    chk("close_tip", bus.transmit_in_progress, 1'b0);
    tick();
    chk("done_state", dbg_state, S_DONE);
    chk("done_complete", bus.transmit_complete, 1'b1);
    chk("done_aborted", bus.aborted, 1'b0);
    tick();
    tick();
    chk("done_hold", bus.transmit_complete, 1'b1);
    bus.next_aline = 1'b1;
    tick();
    bus.next_aline = 1'b0;
    chk("idle_state", dbg_state, S_IDLE);
    chk("idle_complete", bus.transmit_complete, 1'b0);
  endtask

  int d [NUM_CH];

  initial begin
    bus.used_channels  = '0;
    bus.pulse_shape    = '0;
    bus.delays         = '0;
    bus.burst_count    = '0;
    bus.load_delays    = 1'b0;
    bus.start_transmit = 1'b0;
    bus.abort          = 1'b0;
    bus.next_aline     = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_state", dbg_state, S_IDLE);
    chk("rst_switch", bus.switch, 1'b0);
    chk("rst_pulses", bus.ultrasound_pulses, '0);
    chk("rst_sent", bus.pulse_sent, '0);
    chk("rst_flags", {bus.ready, bus.transmit_in_progress, bus.transmit_complete, bus.aborted}, 4'b0);
    rst = 1'b0;

    // start and abort are ignored in IDLE
    bus.start_transmit = 1'b1;
    bus.abort          = 1'b1;
    tick();
    chk("idle_ignore", dbg_state, S_IDLE);
    bus.start_transmit = 1'b0;
    bus.abort          = 1'b0;

    // 1: all channels, staggered delays 0..7, shape 0x5
    for (int i = 0; i < NUM_CH; i++) d[i] = i;
    load_cfg(8'hFF, 32'h0000_0005, d, 4'd1);
    fire();
    run_shot(0, 39);
    finish_txn();

    // 2: only ch0 (delay 3) and ch2 (delay 10) enabled
    for (int i = 0; i < NUM_CH; i++) d[i] = 16'hFFFF;
    d[0] = 3;
    d[2] = 10;
    load_cfg(8'b0000_0101, 32'h0000_0005, d, 4'd1);
    fire();
    run_shot(0, 42);
    finish_txn();

    // 3: three-shot burst, all ones, delay 0, guard gaps between shots
    for (int i = 0; i < NUM_CH; i++) d[i] = 0;
    load_cfg(8'hFF, 32'hFFFF_FFFF, d, 4'd3);
    fire();
    for (int s = 0; s < 3; s++) begin
      run_shot(0, 32);
      if (s < 2) begin
        for (int g = 0; g < GUARD_CYCLES; g++) begin
          chk("guard_state", dbg_state, S_GUARD);
          chk("guard_switch", bus.switch, 1'b1);
          chk("guard_pulses", bus.ultrasound_pulses, '0);
          chk("guard_sent", bus.pulse_sent, '0);
          tick();
        end
      end
    end
    finish_txn();

    // 4: burst 0 acts as one shot; no channels means one TRANSMIT cycle
    load_cfg(8'h00, 32'hFFFF_FFFF, d, 4'd0);
    fire();
    run_shot(0, 0);
    finish_txn();

    // 5: abort at t=5
    load_cfg(8'hFF, 32'hFFFF_FFFF, d, 4'd1);
    fire();
    run_shot(0, 4);
    chk("abort_t5_pulses", bus.ultrasound_pulses, 8'hFF);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_state", dbg_state, S_DONE);
    chk("abort_switch", bus.switch, 1'b0);
    chk("abort_pulses", bus.ultrasound_pulses, '0);
    chk("abort_sent_kept", bus.pulse_sent, '0);
    chk("abort_flags", {bus.transmit_complete, bus.aborted, bus.transmit_in_progress}, 3'b110);
    tick();
    chk("abort_hold", bus.aborted, 1'b1);
    bus.next_aline = 1'b1;
    tick();
    bus.next_aline = 1'b0;
    chk("abort_idle", dbg_state, S_IDLE);
    chk("abort_clear", {bus.transmit_complete, bus.aborted}, 2'b00);

    // Abort wins in ARMED and goes straight to DONE
    load_cfg(8'hFF, 32'h1, d, 4'd1);
    bus.abort          = 1'b1;
    bus.load_delays    = 1'b1;
    bus.start_transmit = 1'b1;
    tick();
    bus.abort          = 1'b0;
    bus.load_delays    = 1'b0;
    bus.start_transmit = 1'b0;
    chk("armed_abort_state", dbg_state, S_DONE);
    chk("armed_abort_flag", bus.aborted, 1'b1);
    bus.next_aline = 1'b1;
    tick();
    bus.next_aline = 1'b0;

    // 6: async reset at t=10, observed before any clock edge
    load_cfg(8'hFF, 32'hFFFF_FFFF, d, 4'd1);
    fire();
    run_shot(0, 9);
    rst = 1'b1;
    #1;
    chk("arst_switch", bus.switch, 1'b0);
    chk("arst_pulses", bus.ultrasound_pulses, '0);
    chk("arst_state", dbg_state, S_IDLE);
    chk("arst_complete", bus.transmit_complete, 1'b0);
    #1;
    rst = 1'b0;
    tick();
    d[0] = 2;
    load_cfg(8'h01, 32'h0000_0005, d, 4'd1);
    fire();
    run_shot(0, 34);
    finish_txn();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
